// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/grant bus between N_PORTS requesters and the shared memory
//   req_i/we_i        per-port request and write flag
//   addr_i/wdata_i    per-port byte address and write data, port p at [p*W +: W]
//   mask_i            per-port byte enables, bit b -> byte b
//   gnt_o/rvalid_o    one-hot grant (combinational) and one-cycle response pulse
//   rdata_o/busy_o    shared response data, transaction in flight
interface mem_arbiter_if #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MASK_W = DATA_WIDTH / 8;
  logic [N_PORTS-1:0]            req_i;
  logic [N_PORTS-1:0]            we_i;
  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [N_PORTS*DATA_WIDTH-1:0] wdata_i;
  logic [N_PORTS*MASK_W-1:0]     mask_i;
  logic [N_PORTS-1:0]            gnt_o;
  logic [N_PORTS-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic                          busy_o;
  modport master (
    output req_i, we_i, addr_i, wdata_i, mask_i,
    input  gnt_o, rvalid_o, rdata_o, busy_o
  );
  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mask_i,
    output gnt_o, rvalid_o, rdata_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port word memory shared by N_PORTS requesters with request/grant arbitration
//   CLK   rising-edge clock
//   RST   asynchronous active-low reset
//   bus   mem_arbiter_if.slave (req/we/addr/wdata/mask in; gnt/rvalid/rdata/busy out)
//   Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module mem_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(MASK_W);
  localparam int PW     = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam int CW     = 3;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         port_q, port_d, win;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d, win_idx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [MASK_W-1:0]     win_mask;
  logic                  take;
  logic                  unused_addr;
  // Grants are suppressed while reset is asserted so no write can slip in.
  assign take = RST && state_q == S_IDLE && |bus.req_i;
`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (bus.req_i[i]) win = PW'(i);
  end
`else
  logic [PW-1:0] rr_q;
  int            p;
  // Scan from the far end so the last hit is the first port after rr_q.
  always_comb begin
    win = '0;
    p   = 0;
    for (int i = N_PORTS; i >= 1; i--) begin
      p = (int'(rr_q) + i) % N_PORTS;
      if (bus.req_i[p]) win = PW'(p);
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) rr_q <= PW'(N_PORTS - 1);
    else if (take) rr_q <= win;
`endif
  assign win_addr  = bus.addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = bus.wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
  assign win_mask  = bus.mask_i[win*MASK_W +: MASK_W];
  assign win_idx   = win_addr[OFF +: DEPTH_LOG2];
  // Address bits outside the word index only alias; they are intentionally dropped.
  assign unused_addr = ^bus.addr_i;
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (take) begin
      port_d  = win;
      idx_d   = win_idx;
      cnt_d   = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
      state_d = LATENCY == 1 ? S_RESP : S_WAIT;
    end
    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == '0 ? S_RESP : S_WAIT;
    end
    if (state_q == S_RESP) begin
      rdata_d = mem_q[idx_q];
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  // Write commits at the grant edge, so RESP already sees the post-write word.
  always_ff @(posedge CLK)
    if (take && bus.we_i[win])
      for (int b = 0; b < MASK_W; b++)
        if (win_mask[b]) mem_q[win_idx][b*8 +: 8] <= win_wdata[b*8 +: 8];
  assign bus.gnt_o    = take ? N_PORTS'(1) << win : '0;
  assign bus.rvalid_o = state_q == S_RESP ? N_PORTS'(1) << port_q : '0;
  assign bus.rdata_o  = state_q == S_RESP ? mem_q[idx_q] : rdata_q;
  assign bus.busy_o   = state_q != S_IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int NP = 2, AW = 32, DW = 32, DL = 10, LAT = 3, MW = DW / 8;
  logic CLK = 0, RST = 0;
  always #5 CLK = ~CLK;
  mem_arbiter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mem_arbiter #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .LATENCY(LAT))
    dut (.CLK(CLK), .RST(RST), .bus(bus));
  logic [NP-1:0] req = '0, we = '0;
  logic [AW-1:0] addr [NP];
  logic [DW-1:0] wdata [NP];
  logic [MW-1:0] mask [NP];
  always_comb begin
    bus.req_i = req;
    bus.we_i  = we;
    for (int p = 0; p < NP; p++) begin
      bus.addr_i[p*AW +: AW]  = addr[p];
      bus.wdata_i[p*DW +: DW] = wdata[p];
      bus.mask_i[p*MW +: MW]  = mask[p];
    end
  end
  typedef struct {int port; logic [DW-1:0] data; int due;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  logic [DW-1:0] ref_mem [1 << DL];
  logic [DW-1:0] last_rdata = '0;
  logic [NP-1:0] seen_gnt = '0, eg;
  logic [NP-1:0] gseq[$];
  logic eb;
  int cyc = 0, next_free = 0, rr_last = NP - 1, checks = 0, failures = 0;
  int w_m, p_m, idx_m;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
    end
  endtask
  // Reference model: one transaction occupies LAT+1 cycles; grant chosen from the
  // bench's own request vector by the arbitration rule.
  always @(negedge CLK) begin
    seen_gnt = bus.gnt_o;
    if (!RST) begin
      check("rst_gnt", bus.gnt_o, 0);
      check("rst_rvalid", bus.rvalid_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_rdata", bus.rdata_o, 0);
      q.delete();
      next_free  = 0;
      rr_last    = NP - 1;
      last_rdata = '0;
    end else begin
      eg = '0;
      eb = cyc < next_free;
      if (!eb && req != '0) begin
        w_m = -1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        for (int i = NP - 1; i >= 0; i--) if (req[i]) w_m = i;
`else
        for (int i = 1; i <= NP; i++) begin
          p_m = (rr_last + i) % NP;
          if (w_m < 0 && req[p_m]) w_m = p_m;
        end
`endif
        eg[w_m]   = 1'b1;
        rr_last   = w_m;
        next_free = cyc + LAT + 1;
        idx_m     = int'(addr[w_m] >> 2) % (1 << DL);
        if (we[w_m])
          for (int b = 0; b < MW; b++)
            if (mask[w_m][b]) ref_mem[idx_m][b*8 +: 8] = wdata[w_m][b*8 +: 8];
        q.push_back('{w_m, ref_mem[idx_m], cyc + LAT});
      end
      check("gnt", bus.gnt_o, eg);
      check("busy", bus.busy_o, eb);
    end
  end
  always @(negedge CLK) if (RST) begin
    if (bus.rvalid_o != '0 || (q.size() > 0 && q[0].due == cyc)) begin
      if (q.size() == 0) check("rvalid_spurious", bus.rvalid_o, 0);
      else begin
        e_mon = q.pop_front();
        check("rvalid_port", bus.rvalid_o, 64'(1) << e_mon.port);
        check("rdata", bus.rdata_o, e_mon.data);
        check("rvalid_time", cyc, e_mon.due);
        last_rdata = e_mon.data;
      end
    end else check("rdata_hold", bus.rdata_o, last_rdata);
  end
  task automatic raise(int p, bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; mask[p] = m;
  endtask
  task automatic step();
    @(posedge CLK); #1;
    for (int p = 0; p < NP; p++) if (seen_gnt[p]) req[p] = 1'b0;
  endtask
  task automatic issue(int p, bit w, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
    raise(p, w, a, d, m);
    for (int k = 0; k < 60 && req[p]; k++) step();
    if (req[p]) begin
      check("issue_timeout", 0, 1);
      req[p] = 1'b0;
    end
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 200 && (req != '0 || q.size() > 0 || cyc < next_free); k++) step();
    if (k == 200) begin
      check("drain_timeout", 0, 1);
      req = '0;
    end
  endtask
  initial begin
    for (int p = 0; p < NP; p++) begin addr[p] = '0; wdata[p] = '0; mask[p] = '0; end
    repeat (3) @(posedge CLK);
    #1 RST = 1;
    for (int i = 0; i < 8; i++) issue(i % NP, 1, AW'(i * 4), $urandom, 4'hF);
    drain();
    issue(1, 1, 'h10, 32'hDEADBEEF, 4'hF);
    issue(1, 0, 'h10, 0, 0);
    drain();
    check("dir_write_read", bus.rdata_o, 32'hDEADBEEF);
    issue(0, 1, 'h10, 32'h00000055, 4'b0001);
    issue(1, 0, 'h10, 0, 0);
    drain();
    check("dir_byte_mask", bus.rdata_o, 32'hDEADBE55);
    issue(0, 1, 'h0, 32'h1234, 4'hF);
    issue(0, 0, 'h1000, 0, 0);
    drain();
    check("dir_alias_high", bus.rdata_o, 32'h1234);
    issue(0, 1, 'h4, 32'h0, 4'h0);
    issue(1, 0, 'h3, 0, 0);
    drain();
    check("dir_alias_low", bus.rdata_o, 32'h1234);
    raise(0, 0, 'h0, 0, 0);
    raise(1, 0, 'h4, 0, 0);
    repeat (4 * (LAT + 1) + 2) begin
      step();
      if (seen_gnt != '0) gseq.push_back(seen_gnt);
      for (int p = 0; p < NP; p++) if (!req[p]) raise(p, 0, AW'(p * 4), 0, 0);
    end
    check("contention_count", gseq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
`ifdef MEM_ARB_FIXED_PRIO_EN
      check("contention_seq", gseq[i], 2'b01);
`else
      check("contention_seq", gseq[i], i % 2 ? 2'b10 : 2'b01);
`endif
    drain();
    issue(0, 1, 'h8, 32'hCAFEF00D, 4'hF);
    RST = 0;
    step();
    step();
    RST = 1;
    issue(1, 0, 'h8, 0, 0);
    drain();
    check("reset_write_persist", bus.rdata_o, 32'hCAFEF00D);
    repeat (300) begin
      step();
      for (int p = 0; p < NP; p++)
        if (!req[p] && $urandom_range(0, 1))
          raise(p, 1'($urandom_range(0, 1)),
                AW'(($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 3)),
                $urandom, MW'($urandom_range(0, 15)));
    end
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
